// File: rtl/neuron_writeback.sv
// Packs the one-neuron-per-strobe ReLU stream into LANES x DW activation rows,
// queues completed rows in a small FIFO and writes them to the activation BRAM.
module neuron_writeback #(
  parameter int LANES = 16,
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int ROWS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DW-1:0]         neuron_in,
  input  logic                  neuron_valid,
  input  logic                  layer_start,
  input  logic [AW-1:0]         base_addr,
  input  logic                  layer_flush,
  input  logic                  bram_wr_ready,
  output logic                  bram_wr_en,
  output logic [AW-1:0]         bram_wr_addr,
  output logic [LANES*DW-1:0]   bram_wr_data,
  output logic [LANES-1:0]      bram_wr_mask,
  output logic                  busy,
  output logic                  overflow,
  output logic [AW-1:0]         rows_written
);

  localparam int LW = $clog2(LANES);
  localparam int PW = $clog2(ROWS);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [PW:0]   FIFO_DEPTH = (PW+1)'(ROWS);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                state, state_n;

  logic [LW-1:0]         lane_cnt;
  logic [LANES*DW-1:0]   pack_data;
  logic [LANES-1:0]      pack_mask;
  logic [AW-1:0]         row_cnt;
  logic [AW-1:0]         base_r;
  logic                  overflow_r;
  logic [AW-1:0]         rows_r;

  logic [LANES*DW-1:0]   mem_data [ROWS];
  logic [AW-1:0]         mem_addr [ROWS];
  logic [LANES-1:0]      mem_mask [ROWS];
  logic [PW:0]           wr_ptr, rd_ptr;
  logic [PW:0]           count, count_n;
  logic                  empty, full;

  logic [LW-1:0]         lane_eff;
  logic [LANES-1:0]      mask_eff;
  logic [AW-1:0]         row_eff;
  logic [AW-1:0]         base_eff;
  logic [LANES*DW-1:0]   data_n;
  logic [LANES-1:0]      mask_n;
  logic                  row_done;
  logic                  push;
  logic                  push_ok;
  logic                  drop;
  logic                  pop;
  logic [LANES*DW-1:0]   push_data;
  logic [AW-1:0]         push_addr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == FIFO_DEPTH);

  // layer_start takes effect before the same-cycle neuron, which lands in lane 0
  always_comb begin
    lane_eff = layer_start ? '0 : lane_cnt;
    mask_eff = layer_start ? '0 : pack_mask;
    row_eff  = layer_start ? '0 : row_cnt;
    base_eff = layer_start ? base_addr : base_r;
    data_n   = pack_data;
    mask_n   = mask_eff;
    if (neuron_valid) begin
      data_n[lane_eff*DW +: DW] = neuron_in;
      mask_n[lane_eff]          = 1'b1;
    end
    row_done = neuron_valid && (lane_eff == LAST_LANE);
    // A completing neuron plus flush still yields a single push
    push     = row_done || (layer_flush && (mask_n != '0));
    for (int i = 0; i < LANES; i++) begin
      push_data[i*DW +: DW] = mask_n[i] ? data_n[i*DW +: DW] : '0;
    end
    push_addr = base_eff + row_eff;
  end

  assign pop     = bram_wr_en && bram_wr_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign count_n = count + (PW+1)'(push_ok) - (PW+1)'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_cnt   <= '0;
      pack_data  <= '0;
      pack_mask  <= '0;
      row_cnt    <= '0;
      base_r     <= '0;
      overflow_r <= 1'b0;
      rows_r     <= '0;
    end else begin
      pack_data <= data_n;
      base_r    <= base_eff;
      if (push) begin
        lane_cnt  <= '0;
        pack_mask <= '0;
        row_cnt   <= row_eff + AW'(1);
      end else begin
        lane_cnt  <= lane_eff + LW'(neuron_valid);
        pack_mask <= mask_n;
        row_cnt   <= row_eff;
      end
      overflow_r <= (layer_start ? 1'b0 : overflow_r) | drop;
      rows_r     <= (layer_start ? '0 : rows_r) + AW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr[PW-1:0]] <= push_data;
      mem_addr[wr_ptr[PW-1:0]] <= push_addr;
      mem_mask[wr_ptr[PW-1:0]] <= mask_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Entering WRITE on the push edge gives the one-cycle row-to-write latency
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!empty || push_ok) state_n = WRITE;
      WRITE:   if (pop && (count_n == '0)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bram_wr_en   = (state == WRITE);
    bram_wr_addr = '0;
    bram_wr_data = '0;
    bram_wr_mask = '0;
    if (bram_wr_en) begin
      bram_wr_addr = mem_addr[rd_ptr[PW-1:0]];
      bram_wr_data = mem_data[rd_ptr[PW-1:0]];
      bram_wr_mask = mem_mask[rd_ptr[PW-1:0]];
    end
    busy         = (lane_cnt != '0) || !empty;
    overflow     = overflow_r;
    rows_written = rows_r;
  end

endmodule

// File: tb/tb_neuron_writeback.sv
// Bench for neuron_writeback: directed table, corner sequences and random traffic
// compared against a queue-based row model.
module tb_neuron_writeback;
  localparam int LANES = 16;
  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int ROWS  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [DW-1:0]       neuron_in;
  logic                neuron_valid;
  logic                layer_start;
  logic [AW-1:0]       base_addr;
  logic                layer_flush;
  logic                bram_wr_ready;
  logic                bram_wr_en;
  logic [AW-1:0]       bram_wr_addr;
  logic [LANES*DW-1:0] bram_wr_data;
  logic [LANES-1:0]    bram_wr_mask;
  logic                busy;
  logic                overflow;
  logic [AW-1:0]       rows_written;

  always #5 clk = ~clk;

  neuron_writeback #(.LANES(LANES), .DW(DW), .AW(AW), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .neuron_in(neuron_in), .neuron_valid(neuron_valid),
    .layer_start(layer_start), .base_addr(base_addr), .layer_flush(layer_flush),
    .bram_wr_ready(bram_wr_ready), .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr),
    .bram_wr_data(bram_wr_data), .bram_wr_mask(bram_wr_mask), .busy(busy),
    .overflow(overflow), .rows_written(rows_written)
  );

  typedef struct {
    logic [AW-1:0]       addr;
    logic [LANES*DW-1:0] data;
    logic [LANES-1:0]    mask;
  } row_t;

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    bit            flush;
    int            exp_writes;
    logic [AW-1:0] exp_rw;
    logic [AW-1:0] exp_addr;
    logic [LANES-1:0] exp_mask;
  } vec_t;

  row_t          q[$];
  int unsigned   pend[$];
  logic [AW-1:0] m_base;
  logic [AW-1:0] m_row;
  bit            m_ovf;
  logic [AW-1:0] m_rw;

  int checks = 0;
  int errors = 0;
  int wcnt;
  logic [AW-1:0]       last_addr;
  logic [LANES-1:0]    last_mask;
  logic [LANES*DW-1:0] last_data;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit en;
    en = (q.size() > 0);
    chk("wr_en", 256'(bram_wr_en), 256'(en));
    if (en) begin
      chk("wr_addr", 256'(bram_wr_addr), 256'(q[0].addr));
      chk("wr_data", bram_wr_data, q[0].data);
      chk("wr_mask", 256'(bram_wr_mask), 256'(q[0].mask));
    end
    chk("busy", 256'(busy), 256'(en || pend.size() > 0));
    chk("overflow", 256'(overflow), 256'(m_ovf));
    chk("rows_written", 256'(rows_written), 256'(m_rw));
  endtask

  task automatic model_update(bit v, logic [DW-1:0] n, bit st, logic [AW-1:0] b,
                              bit fl, bit rdy, bit rs);
    bit   pop, do_push;
    row_t r;
    if (rs) begin
      q.delete(); pend.delete();
      m_base = '0; m_row = '0; m_ovf = 0; m_rw = '0;
      return;
    end
    pop = (q.size() > 0) && rdy;
    if (st) begin
      pend.delete(); m_row = '0; m_rw = '0; m_ovf = 0; m_base = b;
    end
    if (pop) begin
      q.delete(0);
      m_rw = m_rw + 1'b1;
    end
    do_push = 0;
    if (v) begin
      pend.push_back(32'(n));
      if (pend.size() == LANES) do_push = 1;
    end
    if (fl && pend.size() > 0) do_push = 1;
    if (do_push) begin
      r.data = '0;
      r.mask = '0;
      foreach (pend[i]) begin
        r.data[i*DW +: DW] = 16'(pend[i]);
        r.mask[i] = 1'b1;
      end
      r.addr = m_base + m_row;
      if (q.size() < ROWS) q.push_back(r);
      else m_ovf = 1;
      m_row = m_row + 1'b1;
      pend.delete();
    end
  endtask

  task automatic step(bit v, logic [DW-1:0] n, bit st, logic [AW-1:0] b,
                      bit fl, bit rdy, bit rs = 0);
    neuron_valid = v; neuron_in = n; layer_start = st; base_addr = b;
    layer_flush = fl; bram_wr_ready = rdy; reset = rs;
    check_model();
    if (bram_wr_en && rdy && !rs) begin
      wcnt++;
      last_addr = bram_wr_addr;
      last_mask = bram_wr_mask;
      last_data = bram_wr_data;
    end
    @(posedge clk);
    model_update(v, n, st, b, fl, rdy, rs);
    #1;
  endtask

  task automatic idle(int cycles, bit rdy);
    for (int i = 0; i < cycles; i++) step(0, '0, 0, '0, 0, rdy);
  endtask

  vec_t tbl[5];
  logic [LANES*DW-1:0] exp_row;

  initial begin
    tbl[0] = '{16'h0040, 16, 0, 1, 16'd1, 16'h0040, 16'hFFFF};
    tbl[1] = '{16'h0040, 35, 1, 3, 16'd3, 16'h0042, 16'h0007};
    tbl[2] = '{16'hFFFF, 32, 0, 2, 16'd2, 16'h0000, 16'hFFFF};
    tbl[3] = '{16'h1234,  5, 1, 1, 16'd1, 16'h1234, 16'h001F};
    tbl[4] = '{16'h0100,  0, 1, 0, 16'd0, 16'h0000, 16'h0000};

    reset = 1; neuron_valid = 0; neuron_in = '0; layer_start = 0;
    base_addr = '0; layer_flush = 0; bram_wr_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    model_update(0, '0, 0, '0, 0, 0, 1);
    chk("rst_wr_en", 256'(bram_wr_en), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_rows_written", 256'(rows_written), 256'(0));

    for (int k = 0; k < 5; k++) begin
      wcnt = 0;
      step(0, '0, 1, tbl[k].base, 0, 1);
      for (int i = 0; i < tbl[k].n; i++) step(1, DW'(i + 1), 0, '0, 0, 1);
      if (tbl[k].flush) step(0, '0, 0, '0, 1, 1);
      idle(6, 1);
      chk("tbl_writes", 256'(wcnt), 256'(tbl[k].exp_writes));
      chk("tbl_rows_written", 256'(rows_written), 256'(tbl[k].exp_rw));
      chk("tbl_busy_after", 256'(busy), 256'(0));
      if (tbl[k].exp_writes > 0) begin
        chk("tbl_last_addr", 256'(last_addr), 256'(tbl[k].exp_addr));
        chk("tbl_last_mask", 256'(last_mask), 256'(tbl[k].exp_mask));
      end
      if (k == 0) begin
        for (int i = 0; i < LANES; i++) exp_row[i*DW +: DW] = DW'(i + 1);
        chk("tbl_row_values", last_data, exp_row);
      end
    end

    // Overflow: 5 rows against a 4-deep FIFO with the BRAM stalled
    wcnt = 0;
    step(0, '0, 1, 16'h0040, 0, 0);
    for (int i = 0; i < 80; i++) step(1, DW'(i + 100), 0, '0, 0, 0);
    idle(20, 0);
    chk("ovf_flag", 256'(overflow), 256'(1));
    chk("ovf_no_writes", 256'(rows_written), 256'(0));
    idle(10, 1);
    chk("ovf_rows_written", 256'(rows_written), 256'(4));
    chk("ovf_writes", 256'(wcnt), 256'(4));
    chk("ovf_last_addr", 256'(last_addr), 256'(16'h0043));

    // Strobe and flush in the same cycle, partial then full row
    wcnt = 0;
    step(0, '0, 1, 16'h0200, 0, 1);
    for (int i = 0; i < 14; i++) step(1, DW'(i + 1), 0, '0, 0, 1);
    step(1, 16'd15, 0, '0, 1, 1);
    idle(4, 1);
    chk("sf_partial_writes", 256'(wcnt), 256'(1));
    chk("sf_partial_mask", 256'(last_mask), 256'(16'h7FFF));
    for (int i = 0; i < 15; i++) step(1, DW'(i + 1), 0, '0, 0, 1);
    step(1, 16'd16, 0, '0, 1, 1);
    idle(4, 1);
    chk("sf_full_writes", 256'(wcnt), 256'(2));
    chk("sf_full_mask", 256'(last_mask), 256'(16'hFFFF));
    chk("sf_full_addr", 256'(last_addr), 256'(16'h0201));
    chk("sf_rows_written", 256'(rows_written), 256'(2));

    // Reset mid-row while a queued row is being offered
    step(0, '0, 1, 16'h0300, 0, 0);
    for (int i = 0; i < 21; i++) step(1, DW'(i + 7), 0, '0, 0, 0);
    chk("rst_pre_wr_en", 256'(bram_wr_en), 256'(1));
    step(0, '0, 0, '0, 0, 0, 1);
    chk("rst2_wr_en", 256'(bram_wr_en), 256'(0));
    chk("rst2_addr", 256'(bram_wr_addr), 256'(0));
    chk("rst2_data", bram_wr_data, 256'(0));
    chk("rst2_mask", 256'(bram_wr_mask), 256'(0));
    chk("rst2_busy", 256'(busy), 256'(0));
    chk("rst2_overflow", 256'(overflow), 256'(0));
    chk("rst2_rows_written", 256'(rows_written), 256'(0));
    wcnt = 0;
    step(1, 16'hAAAA, 0, '0, 1, 1);
    idle(4, 1);
    chk("rst2_writes", 256'(wcnt), 256'(1));
    chk("rst2_lane0_mask", 256'(last_mask), 256'(16'h0001));
    chk("rst2_lane0_data", 256'(last_data[15:0]), 256'(16'hAAAA));

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 63) == 0,
           AW'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end
    idle(10, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_writeback.md
# neuron_writeback

Downstream stage of the accelerator datapath. Takes the one-neuron-per-strobe ReLU output stream and packs 16 consecutive neurons into one 256-bit activation row. Buffers completed rows in a small row FIFO and writes them to the activation BRAM over a valid/ready port, so the next layer sees the same 16x16-bit row layout that the parallel multiplier consumes.

## Interface
Parameters:
- LANES, 16, neurons per BRAM row
- DW, 16, neuron width in bits
- AW, 16, BRAM row-address width
- ROWS, 4, row-FIFO depth (power of two)

Ports:
- clk  in  1  single clock; everything is on the rising edge
- reset  in  1  synchronous, active-high
- neuron_in  in  DW  ReLU output neuron
- neuron_valid  in  1  one-cycle strobe per neuron, driven by the ReLU done strobe
- layer_start  in  1  pulse; loads base_addr, clears lane and row counters
- base_addr  in  AW  first output row address of the layer
- layer_flush  in  1  pulse; pushes a partially filled row
- bram_wr_ready  in  1  BRAM port accepts the write this cycle
- bram_wr_en  out  1  write request valid
- bram_wr_addr  out  AW  row address
- bram_wr_data  out  LANES*DW  lane i at bits [i*DW +: DW]
- bram_wr_mask  out  LANES  per-lane write enable
- busy  out  1  high if the pack register or the FIFO holds any data
- overflow  out  1  sticky; a row was dropped because the FIFO was full
- rows_written  out  AW  count of completed BRAM writes since layer_start

## Operation
- Pack register: lane_cnt from 0 to LANES-1.
  - Each neuron_valid writes neuron_in into lane lane_cnt, sets that lane's mask bit, and increments lane_cnt.
- Row completion: a neuron arriving at lane_cnt==LANES-1 completes the row.
  - Push {row, mask=all ones, addr=base+row_cnt} into the FIFO; row_cnt++, lane_cnt=0, pack mask cleared.
- Flush: layer_flush with lane_cnt>0 pushes the partial row.
  - Unfilled lanes carry zero data and mask 0.
  - With lane_cnt==0, flush is a no-op.
- Same-cycle neuron_valid and layer_flush: the neuron is packed first, then the (now updated) row is flushed. If that neuron completes the row, exactly one full row is pushed.
- FIFO full at a push: the row is dropped, overflow is set, pack state clears, and row_cnt still increments so later addresses stay correct.
  - A same-cycle pop frees a slot, so the push succeeds.
- Write FSM has two states:
  - IDLE to WRITE when the FIFO is non-empty.
  - In WRITE, bram_wr_en=1 with the head entry.
  - On bram_wr_en && bram_wr_ready: pop and increment rows_written. Stay in WRITE if more entries remain, else return to IDLE.
- Handshake: once bram_wr_en is high, addr, data and mask stay stable until accepted. bram_wr_en does not drop without acceptance.
- layer_start:
  - Clears lane_cnt, pack mask, row_cnt, rows_written and overflow, and loads base_addr.
  - Rows already queued still drain with their stored addresses.
  - A neuron_valid in the same cycle lands in lane 0 of the new layer.
- Addresses: base+row_cnt is computed modulo 2^AW; wrap is silent.
- Reset: lane_cnt, row_cnt, the FIFO pointers and the FSM (to IDLE) clear. All outputs read 0: bram_wr_en, bram_wr_addr, bram_wr_data, bram_wr_mask, busy, overflow, rows_written.

## Timing
- The neuron is captured on the edge that ends its strobe cycle.
- Full-row latency: 16th strobe in cycle T puts bram_wr_en high in T+1 (FIFO empty, FSM idle). Accepted in T+1 if bram_wr_ready=1.
- Flush latency: flush in cycle T puts bram_wr_en high in T+1.
- Sustained throughput: one row write per cycle while bram_wr_ready=1.
- A neuron strobe is accepted every cycle, with no back-pressure on the input side.
- busy drops the cycle after the last accepted write, provided the pack register is empty.

## Test plan
- layer_start with base_addr=0x0040, then 16 strobes of values 1..16, ready=1 -> one write at T+1: addr 0x0040, lane0=1 ... lane15=16, mask=0xFFFF. rows_written=1, busy=0 after.
- 35 strobes, then flush, ready=1 -> three writes at 0x0040, 0x0041, 0x0042. The third has mask=0x0007, lanes 3..15 zero, rows_written=3.
- ready=0 for 100 cycles while 80 strobes arrive (5 rows, ROWS=4):
  - overflow=1; row 4 is dropped.
  - After ready=1, writes go to base+0..3 with held, stable data, and rows_written=4.
- 15th strobe and layer_flush in the same cycle, then a 16th-position strobe paired with flush -> respectively one write with mask 0x7FFF, then one full 0xFFFF row; no empty-row write.
- base_addr=0xFFFF, 32 strobes -> writes to 0xFFFF then 0x0000.
- reset asserted mid-row with a queued entry and bram_wr_en high -> the next cycle shows every output 0, and later strobes start again at lane 0.
